ddr_req_arbiter: RTL and testbench
==================================

DDR_REQ_ARBITER -- requirements
Module: ddr_req_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of requesting channels (2..8).
REQ-002 SHALL have parameter ADDR_W, default 25, DDR address width.
REQ-003 SHALL have parameter DATA_W, default 128, DDR data width.
REQ-004 SHALL have parameter CMD_DEPTH, default 16, command FIFO depth (power of 2).
REQ-005 SHALL have parameter TAG_DEPTH, default 8, outstanding-read tag FIFO depth (power of 2).
REQ-006 SHALL use one clock and a synchronous, active-high reset.
REQ-007 SHALL have port clk_133M, input, 1, sole clock.
REQ-008 SHALL have port rst_133M, input, 1, synchronous active-high reset.
REQ-009 SHALL have port init_done, input, 1, DDR controller ready.
REQ-010 SHALL have port req, input, NUM_CH, per-channel request, held until granted.
REQ-011 SHALL have port req_wr, input, NUM_CH, per-channel 1=write, 0=read.
REQ-012 SHALL have port req_addr, input, NUM_CH*ADDR_W, flattened; channel i at [i*ADDR_W +: ADDR_W].
REQ-013 SHALL have port req_wdata, input, NUM_CH*DATA_W, flattened; same packing.
REQ-014 SHALL have port gnt, output, NUM_CH, one-hot; request accepted this cycle.
REQ-015 SHALL have port cmd_busy, input, 1, DDR controller cannot take a command.
REQ-016 SHALL have ports cmd (output, 4), cmd_valid (output, 1), ddr_address (output, ADDR_W), ddr_wr_data (output, DATA_W), the command to the controller.
REQ-017 SHALL have ports ddr_data_valid (input, 1) and ddr_rd_data (input, DATA_W), the read return.
REQ-018 SHALL have ports rd_data (output, DATA_W) and rd_valid (output, NUM_CH, one-hot), the routed read data.
REQ-019 SHALL have port ret_err, output, 1, sticky flag: read return with no outstanding tag.

Function
REQ-020 SHALL grant no request while init_done=0 or the command FIFO is full.
REQ-021 SHALL block read requests while the tag FIFO is full; write requests remain eligible.
REQ-022 SHALL grant at most one eligible channel per cycle, round-robin starting at last-granted+1.
REQ-023 SHALL assert gnt combinationally in the same cycle as the accepted req; the requester drops or advances req on the next edge.
REQ-024 SHALL push {cmd, wdata, addr} into the command FIFO on grant; cmd=CMD_WR for a write, CMD_RD for a read, wdata zero for a read.
REQ-025 SHALL push the granted channel index into the tag FIFO on a read grant, in command order.
REQ-026 SHALL drive the issue FSM as follows:
- S_INIT -> S_IDLE on init_done.
- S_IDLE -> S_POP when the command FIFO is non-empty and cmd_busy=0.
- S_POP -> S_CMD (one FIFO read latency).
- S_CMD -> S_IDLE.
REQ-027 SHALL pulse cmd_valid for exactly one cycle in S_CMD, with cmd, ddr_address and ddr_wr_data held stable until the next S_CMD.
REQ-028 SHALL, on ddr_data_valid, pop the tag FIFO and one cycle later drive rd_data=ddr_rd_data and rd_valid one-hot at the popped channel for one cycle.
REQ-029 SHALL, on ddr_data_valid with the tag FIFO empty, set ret_err, drive no rd_valid, and leave ret_err set until reset.
REQ-030 SHALL support a tag push and a tag pop in the same cycle, including when the FIFO is full (pop frees space) or empty (pop is invalid, REQ-029).
REQ-031 SHALL wrap the round-robin pointer from NUM_CH-1 to 0.

Reset
REQ-032 SHALL, on rst_133M:
- clear gnt, cmd_valid, cmd, ddr_address, ddr_wr_data, rd_data, rd_valid and ret_err to 0;
- flush both FIFOs;
- set the round-robin pointer to channel 0 and the FSM to S_INIT.
REQ-033 SHALL discard commands and outstanding tags in flight when reset arrives mid-operation; returns arriving after reset set ret_err.

Configuration
REQ-034 SHALL, with DDR_ARB_CH0_PRIO_EN defined, give channel 0 (camera write path) fixed priority over all channels and apply round-robin among channels 1..NUM_CH-1.
REQ-035 SHALL, without DDR_ARB_CH0_PRIO_EN, apply pure round-robin across all channels.

Structure
REQ-036 SHALL place CMD_RD=4'b0011, CMD_WR=4'b0100, the FSM state encoding and the command-word packing widths in shared package ddr_arb_pkg.
REQ-037 SHALL instantiate the generic sub-module sync_fifo (parameters WIDTH and DEPTH; full, empty, one-cycle read latency) twice: once for commands, once for tags.

Verification
REQ-038 SHALL cover: all 4 channels asserting a read at once -> grants to ch0, ch1, ch2, ch3 on consecutive cycles; four cmd_valid pulses with CMD_RD; returns routed with rd_valid=0001, 0010, 0100, 1000.
REQ-039 SHALL cover: TAG_DEPTH=8, 8 reads issued and no returns, then a read and a write requested -> read withheld, write granted.
REQ-040 SHALL cover: ch2 writes addr 0x0000100, data 0xA5..A5, with cmd_busy=1 for 5 cycles -> no cmd_valid until cmd_busy=0; then cmd=0100, ddr_address=0x0000100, ddr_wr_data=0xA5..A5.
REQ-041 SHALL cover: ddr_data_valid pulse with no outstanding read -> ret_err=1 and held; rd_valid=0.
REQ-042 SHALL cover: with DDR_ARB_CH0_PRIO_EN, ch0 and ch1 requesting continuously -> only ch0 granted; without it -> grants alternate ch0/ch1.
REQ-043 SHALL cover: reset asserted with 3 commands queued -> no cmd_valid after reset; FSM stays in S_INIT until init_done.

Source files
------------

// File: rtl/ddr_arb_pkg.sv
// -----------------------------------------------------------------------------
// ddr_arb_pkg
// Shared definitions for the DDR request arbiter: controller command codes,
// issue-FSM state encoding and command-word packing helpers.
// No ports.
// -----------------------------------------------------------------------------
package ddr_arb_pkg;

    localparam int CMD_W = 4;

    localparam logic [CMD_W-1:0] CMD_RD = 4'b0011;
    localparam logic [CMD_W-1:0] CMD_WR = 4'b0100;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_POP  = 2'd2,
        S_CMD  = 2'd3
    } issue_state_t;

    // Command word layout, MSB to LSB: {cmd, wdata, addr}
    function automatic int cmd_word_w(input int addr_w, input int data_w);
        return CMD_W + data_w + addr_w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Generic single-clock FIFO with registered read data (one-cycle read
// latency). DEPTH must be a power of two. A write while full is accepted
// when a read happens in the same cycle, since the read frees the slot.
//
// Ports:
//   i_clk      clock
//   i_rst      synchronous active-high reset (flushes contents, clears o_rd_data)
//   i_wr_en    push i_wr_data
//   i_wr_data  write data
//   i_rd_en    pop; head entry appears on o_rd_data after the next edge
//   o_rd_data  registered read data
//   o_full     no free entry
//   o_empty    no valid entry
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_rd_data;
    logic             w_do_wr;
    logic             w_do_rd;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_rd_data = r_rd_data;

    assign w_do_rd = i_rd_en && !o_empty;
    assign w_do_wr = i_wr_en && (!o_full || w_do_rd);

    always_ff @(posedge i_clk) begin
        if (w_do_wr) begin
            r_mem[r_wptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_do_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rptr    <= r_rptr + 1'b1;
                r_rd_data <= r_mem[r_rptr];
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ddr_req_arbiter.sv
// -----------------------------------------------------------------------------
// ddr_req_arbiter
// Arbitrates NUM_CH read/write requesters onto one DDR controller command
// port. Accepted requests are queued as {cmd, wdata, addr} in a command FIFO
// and issued by a small FSM; read grants also queue the channel index in a
// tag FIFO so read returns can be routed back in command order.
//
// Build option: define DDR_ARB_CH0_PRIO_EN to give channel 0 (camera write
// path) fixed priority, with round-robin among channels 1..NUM_CH-1.
// Default build is pure round-robin over all channels.
//
// Ports:
//   clk_133M, rst_133M   clock, synchronous active-high reset
//   init_done            controller ready; no grants until set
//   req/req_wr           per-channel request and direction (1=write)
//   req_addr/req_wdata   flattened per-channel address / write data
//   gnt                  one-hot, combinational, request accepted this cycle
//   cmd_busy             controller cannot take a command
//   cmd/cmd_valid/ddr_address/ddr_wr_data   command to the controller
//   ddr_data_valid/ddr_rd_data              read return from the controller
//   rd_data/rd_valid     routed read data, rd_valid one-hot by channel
//   ret_err              sticky: read return with no outstanding tag
//
// Issue FSM:
//   state  | meaning
//   S_INIT | waiting for init_done
//   S_IDLE | waiting for a queued command and cmd_busy=0
//   S_POP  | command FIFO read in progress
//   S_CMD  | cmd_valid pulse with the popped command
// -----------------------------------------------------------------------------
module ddr_req_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int ADDR_W    = 25,
    parameter int DATA_W    = 128,
    parameter int CMD_DEPTH = 16,
    parameter int TAG_DEPTH = 8
) (
    input  logic                     clk_133M,
    input  logic                     rst_133M,
    input  logic                     init_done,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH-1:0]        req_wr,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*DATA_W-1:0] req_wdata,
    output logic [NUM_CH-1:0]        gnt,
    input  logic                     cmd_busy,
    output logic [CMD_W-1:0]         cmd,
    output logic                     cmd_valid,
    output logic [ADDR_W-1:0]        ddr_address,
    output logic [DATA_W-1:0]        ddr_wr_data,
    input  logic                     ddr_data_valid,
    input  logic [DATA_W-1:0]        ddr_rd_data,
    output logic [DATA_W-1:0]        rd_data,
    output logic [NUM_CH-1:0]        rd_valid,
    output logic                     ret_err
);

    localparam int CMD_WORD_W = cmd_word_w(ADDR_W, DATA_W);
    localparam int TAG_W      = $clog2(NUM_CH);

    logic                  w_cmd_full;
    logic                  w_cmd_empty;
    logic                  w_cmd_pop;
    logic [CMD_WORD_W-1:0] w_cmd_din;
    logic [CMD_WORD_W-1:0] w_cmd_dout;
    logic                  w_tag_full;
    logic                  w_tag_empty;
    logic                  w_tag_push;
    logic [TAG_W-1:0]      w_tag_dout;
    logic                  w_tag_room;

    logic [NUM_CH-1:0]     w_elig;
    logic [NUM_CH-1:0]     w_gnt;
    logic [TAG_W-1:0]      w_gnt_idx;
    logic                  w_gnt_vld;
    logic [TAG_W-1:0]      w_nxt_ptr;
    logic [TAG_W-1:0]      r_rr_ptr;

    logic                  w_sel_wr;
    logic [ADDR_W-1:0]     w_sel_addr;
    logic [DATA_W-1:0]     w_sel_wdata;
    logic [DATA_W-1:0]     w_push_wdata;

    issue_state_t          r_state;
    issue_state_t          w_state_nxt;

    logic                  r_ret_pend;
    logic [DATA_W-1:0]     r_rd_data;
    logic                  r_ret_err;

    // A return in the same cycle pops a tag, so a full tag FIFO can still
    // take a new read tag then.
    assign w_tag_room = !w_tag_full || ddr_data_valid;

    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_elig[i] = req[i] && (req_wr[i] || w_tag_room);
        end
        if (rst_133M || !init_done || w_cmd_full) begin
            w_elig = '0;
        end
    end

    // Search order starts at r_rr_ptr and wraps; offset k selects channel i
    // when r_rr_ptr + k equals i modulo NUM_CH.
    always_comb begin
        w_gnt     = '0;
        w_gnt_idx = '0;
        w_gnt_vld = 1'b0;
`ifdef DDR_ARB_CH0_PRIO_EN
        if (w_elig[0]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = '0;
            w_gnt[0]  = 1'b1;
        end
`endif
        for (int k = 0; k < NUM_CH; k++) begin
            for (int i = 0; i < NUM_CH; i++) begin
`ifdef DDR_ARB_CH0_PRIO_EN
                if (!w_gnt_vld && (i != 0) && w_elig[i] &&
                    ((int'(r_rr_ptr) + k == i) || (int'(r_rr_ptr) + k == i + NUM_CH))) begin
`else
                if (!w_gnt_vld && w_elig[i] &&
                    ((int'(r_rr_ptr) + k == i) || (int'(r_rr_ptr) + k == i + NUM_CH))) begin
`endif
                    w_gnt_vld = 1'b1;
                    w_gnt_idx = TAG_W'(i);
                    w_gnt[i]  = 1'b1;
                end
            end
        end
    end

    assign gnt       = w_gnt;
    assign w_nxt_ptr = (w_gnt_idx == TAG_W'(NUM_CH - 1)) ? '0 : w_gnt_idx + 1'b1;

    always_ff @(posedge clk_133M) begin
        if (rst_133M) begin
            r_rr_ptr <= '0;
        end else if (w_gnt_vld) begin
`ifdef DDR_ARB_CH0_PRIO_EN
            // ch0 sits outside the rotation; its grants leave the pointer alone
            if (w_gnt_idx != '0) begin
                r_rr_ptr <= w_nxt_ptr;
            end
`else
            r_rr_ptr <= w_nxt_ptr;
`endif
        end
    end

    always_comb begin
        w_sel_wr    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_gnt[i]) begin
                w_sel_wr    = req_wr[i];
                w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
        w_push_wdata = w_sel_wr ? w_sel_wdata : '0;
        w_cmd_din    = {(w_sel_wr ? CMD_WR : CMD_RD), w_push_wdata, w_sel_addr};
    end

    assign w_tag_push = w_gnt_vld && !w_sel_wr;

    sync_fifo #(
        .WIDTH (CMD_WORD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .i_clk     (clk_133M),
        .i_rst     (rst_133M),
        .i_wr_en   (w_gnt_vld),
        .i_wr_data (w_cmd_din),
        .i_rd_en   (w_cmd_pop),
        .o_rd_data (w_cmd_dout),
        .o_full    (w_cmd_full),
        .o_empty   (w_cmd_empty)
    );

    sync_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .i_clk     (clk_133M),
        .i_rst     (rst_133M),
        .i_wr_en   (w_tag_push),
        .i_wr_data (w_gnt_idx),
        .i_rd_en   (ddr_data_valid),
        .o_rd_data (w_tag_dout),
        .o_full    (w_tag_full),
        .o_empty   (w_tag_empty)
    );

    always_ff @(posedge clk_133M) begin
        if (rst_133M) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_pop   = 1'b0;
        case (r_state)
            S_INIT: begin
                if (init_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (!w_cmd_empty && !cmd_busy) begin
                    w_state_nxt = S_POP;
                end
            end
            S_POP: begin
                w_cmd_pop   = 1'b1;
                w_state_nxt = S_CMD;
            end
            S_CMD: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_INIT;
            end
        endcase
    end

    // The FIFO read register only changes on a pop in S_POP, so the command
    // fields stay stable from one S_CMD to the next.
    assign cmd_valid   = (r_state == S_CMD);
    assign cmd         = w_cmd_dout[CMD_WORD_W-1 -: CMD_W];
    assign ddr_wr_data = w_cmd_dout[ADDR_W +: DATA_W];
    assign ddr_address = w_cmd_dout[ADDR_W-1:0];

    always_ff @(posedge clk_133M) begin
        if (rst_133M) begin
            r_ret_pend <= 1'b0;
            r_rd_data  <= '0;
            r_ret_err  <= 1'b0;
        end else begin
            r_ret_pend <= ddr_data_valid && !w_tag_empty;
            if (ddr_data_valid && !w_tag_empty) begin
                r_rd_data <= ddr_rd_data;
            end
            if (ddr_data_valid && w_tag_empty) begin
                r_ret_err <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_valid = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rd_valid[i] = r_ret_pend && (w_tag_dout == TAG_W'(i));
        end
    end

    assign rd_data = r_rd_data;
    assign ret_err = r_ret_err;

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ddr_req_arbiter
// Scoreboard bench for ddr_req_arbiter (NUM_CH=4, TAG_DEPTH=8). Expected
// commands and read returns are queued when stimulus is applied and compared
// by a negedge monitor as cmd_valid / rd_valid appear.
// -----------------------------------------------------------------------------
module tb_ddr_req_arbiter;
    import ddr_arb_pkg::*;

    localparam int NUM_CH    = 4;
    localparam int ADDR_W    = 25;
    localparam int DATA_W    = 128;
    localparam int CMD_DEPTH = 16;
    localparam int TAG_DEPTH = 8;

    logic                     clk_133M = 1'b0;
    logic                     rst_133M;
    logic                     init_done;
    logic [NUM_CH-1:0]        req;
    logic [NUM_CH-1:0]        req_wr;
    logic [NUM_CH*ADDR_W-1:0] req_addr;
    logic [NUM_CH*DATA_W-1:0] req_wdata;
    logic [NUM_CH-1:0]        gnt;
    logic                     cmd_busy;
    logic [3:0]               cmd;
    logic                     cmd_valid;
    logic [ADDR_W-1:0]        ddr_address;
    logic [DATA_W-1:0]        ddr_wr_data;
    logic                     ddr_data_valid;
    logic [DATA_W-1:0]        ddr_rd_data;
    logic [DATA_W-1:0]        rd_data;
    logic [NUM_CH-1:0]        rd_valid;
    logic                     ret_err;

    typedef struct packed {
        logic [3:0]        cmd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_exp_t;

    typedef struct packed {
        logic [NUM_CH-1:0] oh;
        logic [DATA_W-1:0] data;
    } ret_exp_t;

    cmd_exp_t exp_cmd[$];
    ret_exp_t exp_ret[$];
    cmd_exp_t ec;
    ret_exp_t er;

    int n_checks = 0;
    int n_pass   = 0;

    ddr_req_arbiter #(
        .NUM_CH    (NUM_CH),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .CMD_DEPTH (CMD_DEPTH),
        .TAG_DEPTH (TAG_DEPTH)
    ) dut (
        .clk_133M       (clk_133M),
        .rst_133M       (rst_133M),
        .init_done      (init_done),
        .req            (req),
        .req_wr         (req_wr),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .gnt            (gnt),
        .cmd_busy       (cmd_busy),
        .cmd            (cmd),
        .cmd_valid      (cmd_valid),
        .ddr_address    (ddr_address),
        .ddr_wr_data    (ddr_wr_data),
        .ddr_data_valid (ddr_data_valid),
        .ddr_rd_data    (ddr_rd_data),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .ret_err        (ret_err)
    );

    always #4 clk_133M = ~clk_133M;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic cmd_exp_t mk_cmd(input logic wr, input logic [ADDR_W-1:0] a,
                                        input logic [DATA_W-1:0] d);
        cmd_exp_t r;
        r.cmd  = wr ? 4'b0100 : 4'b0011;
        r.addr = a;
        r.data = wr ? d : '0;
        return r;
    endfunction

    function automatic ret_exp_t mk_ret(input logic [NUM_CH-1:0] oh, input logic [DATA_W-1:0] d);
        ret_exp_t r;
        r.oh   = oh;
        r.data = d;
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] ret_pat(input int k);
        logic [31:0] w;
        w = 32'hC0DE0000 + k;
        return {4{w}};
    endfunction

    always @(negedge clk_133M) begin
        if (cmd_valid) begin
            if (exp_cmd.size() == 0) begin
                check("cmd_unexpected", {255'd0, cmd_valid}, 256'd0);
            end else begin
                ec = exp_cmd.pop_front();
                check("cmd_code", cmd, ec.cmd);
                check("cmd_addr", ddr_address, ec.addr);
                check("cmd_wdata", ddr_wr_data, ec.data);
            end
        end
        if (rd_valid != '0) begin
            if (exp_ret.size() == 0) begin
                check("ret_unexpected", rd_valid, 256'd0);
            end else begin
                er = exp_ret.pop_front();
                check("ret_rd_valid", rd_valid, er.oh);
                check("ret_rd_data", rd_data, er.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk_133M);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
        req_wr[ch]                   = wr;
        req_addr[ch*ADDR_W +: ADDR_W] = a;
        req_wdata[ch*DATA_W +: DATA_W] = d;
    endtask

    task automatic do_reset();
        rst_133M       = 1'b1;
        req            = '0;
        req_wr         = '0;
        cmd_busy       = 1'b0;
        ddr_data_valid = 1'b0;
        repeat (2) tick();
        exp_cmd.delete();
        exp_ret.delete();
        rst_133M = 1'b0;
    endtask

    task automatic drain_cmds(input string tag);
        int n;
        n = 0;
        while (exp_cmd.size() != 0 && n < 300) begin
            @(negedge clk_133M);
            n++;
        end
        check(tag, exp_cmd.size(), 256'd0);
    endtask

    task automatic drain_rets(input string tag);
        int n;
        n = 0;
        while (exp_ret.size() != 0 && n < 50) begin
            @(negedge clk_133M);
            n++;
        end
        check(tag, exp_ret.size(), 256'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [NUM_CH-1:0] exp_g;

        rst_133M       = 1'b1;
        init_done      = 1'b0;
        cmd_busy       = 1'b0;
        req            = '0;
        req_wr         = '0;
        req_addr       = '0;
        req_wdata      = '0;
        ddr_data_valid = 1'b0;
        ddr_rd_data    = '0;
        repeat (3) tick();

        // reset state, and no grant while reset is held
        req       = '1;
        init_done = 1'b1;
        @(negedge clk_133M);
        check("rst_gnt", gnt, 256'd0);
        tick();
        rst_133M  = 1'b0;
        req       = '0;
        init_done = 1'b0;
        @(negedge clk_133M);
        check("rst_cmd_valid", cmd_valid, 256'd0);
        check("rst_cmd", cmd, 256'd0);
        check("rst_ddr_address", ddr_address, 256'd0);
        check("rst_ddr_wr_data", ddr_wr_data, 256'd0);
        check("rst_rd_data", rd_data, 256'd0);
        check("rst_rd_valid", rd_valid, 256'd0);
        check("rst_ret_err", ret_err, 256'd0);

        // no grant before init_done
        set_ch(0, 1'b1, 25'h0000040, {8{16'h7E7E}});
        req[0] = 1'b1;
        repeat (3) begin
            @(negedge clk_133M);
            check("noinit_gnt", gnt, 256'd0);
        end
        tick();
        init_done = 1'b1;
        @(negedge clk_133M);
        check("init_gnt", gnt, 256'd1);
        exp_cmd.push_back(mk_cmd(1'b1, 25'h0000040, {8{16'h7E7E}}));
        tick();
        req = '0;
        drain_cmds("init_cmd_drain");

        // four simultaneous reads -> ch0..ch3 in order, returns routed back
        do_reset();
        for (int i = 0; i < NUM_CH; i++) set_ch(i, 1'b0, 25'h0000010 + 25'(i), '0);
        req = '1;
        for (int k = 0; k < NUM_CH; k++) begin
            @(negedge clk_133M);
            check("rr4_gnt", gnt, 256'd1 << k);
            exp_cmd.push_back(mk_cmd(1'b0, 25'h0000010 + 25'(k), '0));
            tick();
            req[k] = 1'b0;
        end
        // pointer wrapped past ch3 back to ch0
        set_ch(0, 1'b1, 25'h0000020, {16{8'h11}});
        set_ch(3, 1'b1, 25'h0000023, {16{8'h33}});
        req = 4'b1001;
        @(negedge clk_133M);
        check("wrap_gnt0", gnt, 256'd1);
        exp_cmd.push_back(mk_cmd(1'b1, 25'h0000020, {16{8'h11}}));
        tick();
        req[0] = 1'b0;
        @(negedge clk_133M);
        check("wrap_gnt3", gnt, 256'd8);
        exp_cmd.push_back(mk_cmd(1'b1, 25'h0000023, {16{8'h33}}));
        tick();
        req = '0;
        drain_cmds("rr4_cmd_drain");
        for (int k = 0; k < NUM_CH; k++) begin
            exp_ret.push_back(mk_ret(NUM_CH'(1) << k, ret_pat(k)));
            ddr_data_valid = 1'b1;
            ddr_rd_data    = ret_pat(k);
            tick();
        end
        ddr_data_valid = 1'b0;
        drain_rets("rr4_ret_drain");

        // tag FIFO full: reads withheld, writes still granted
        do_reset();
        set_ch(2, 1'b1, 25'h0000280, {16{8'h3C}});
        for (int k = 0; k < TAG_DEPTH; k++) begin
            set_ch(1, 1'b0, 25'h0000200 + 25'(k), '0);
            req[1] = 1'b1;
            @(negedge clk_133M);
            check("tagfill_gnt", gnt, 256'd2);
            exp_cmd.push_back(mk_cmd(1'b0, 25'h0000200 + 25'(k), '0));
            tick();
        end
        set_ch(1, 1'b0, 25'h0000208, '0);
        req[2] = 1'b1;
        @(negedge clk_133M);
        check("tagfull_wr_gnt", gnt, 256'd4);
        exp_cmd.push_back(mk_cmd(1'b1, 25'h0000280, {16{8'h3C}}));
        tick();
        req[2] = 1'b0;
        @(negedge clk_133M);
        check("tagfull_rd_blocked", gnt, 256'd0);
        tick();
        // a return in the same cycle frees a slot for the held read
        set_ch(1, 1'b0, 25'h0000300, '0);
        exp_ret.push_back(mk_ret(4'b0010, ret_pat(100)));
        ddr_data_valid = 1'b1;
        ddr_rd_data    = ret_pat(100);
        @(negedge clk_133M);
        check("tagfull_pop_push_gnt", gnt, 256'd2);
        exp_cmd.push_back(mk_cmd(1'b0, 25'h0000300, '0));
        tick();
        req[1] = 1'b0;
        for (int k = 1; k <= TAG_DEPTH; k++) begin
            exp_ret.push_back(mk_ret(4'b0010, ret_pat(100 + k)));
            ddr_rd_data = ret_pat(100 + k);
            tick();
        end
        ddr_data_valid = 1'b0;
        drain_cmds("tagfull_cmd_drain");
        drain_rets("tagfull_ret_drain");
        check("tagfull_no_err", ret_err, 256'd0);

        // cmd_busy holds off issue
        do_reset();
        cmd_busy = 1'b1;
        set_ch(2, 1'b1, 25'h0000100, {16{8'hA5}});
        req[2] = 1'b1;
        @(negedge clk_133M);
        check("busy_gnt", gnt, 256'd4);
        exp_cmd.push_back(mk_cmd(1'b1, 25'h0000100, {16{8'hA5}}));
        tick();
        req[2] = 1'b0;
        repeat (5) begin
            @(negedge clk_133M);
            check("busy_hold_cmd_valid", cmd_valid, 256'd0);
        end
        cmd_busy = 1'b0;
        drain_cmds("busy_cmd_drain");

        // return with nothing outstanding
        do_reset();
        @(negedge clk_133M);
        check("err_clear", ret_err, 256'd0);
        ddr_data_valid = 1'b1;
        ddr_rd_data    = '1;
        tick();
        ddr_data_valid = 1'b0;
        @(negedge clk_133M);
        check("err_set", ret_err, 256'd1);
        check("err_no_rd_valid", rd_valid, 256'd0);
        repeat (5) tick();
        @(negedge clk_133M);
        check("err_held", ret_err, 256'd1);

        // ch0 and ch1 requesting continuously
        do_reset();
        set_ch(0, 1'b1, 25'h0000500, {8{16'h0A0A}});
        set_ch(1, 1'b1, 25'h0000600, {8{16'h1B1B}});
        req = 4'b0011;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_133M);
`ifdef DDR_ARB_CH0_PRIO_EN
            exp_g = 4'b0001;
`else
            exp_g = (k % 2 == 0) ? 4'b0001 : 4'b0010;
`endif
            check("ch01_gnt", gnt, exp_g);
            if (exp_g == 4'b0001) exp_cmd.push_back(mk_cmd(1'b1, 25'h0000500, {8{16'h0A0A}}));
            else                  exp_cmd.push_back(mk_cmd(1'b1, 25'h0000600, {8{16'h1B1B}}));
            tick();
        end
        req = '0;
        drain_cmds("ch01_cmd_drain");

        // reset with commands and tags in flight
        do_reset();
        cmd_busy = 1'b1;
        set_ch(3, 1'b0, 25'h0000700, '0);
        req[3] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_133M);
            check("midrst_queue_gnt", gnt, 256'd8);
            tick();
        end
        req       = '0;
        rst_133M  = 1'b1;
        init_done = 1'b0;
        repeat (2) tick();
        exp_cmd.delete();
        exp_ret.delete();
        rst_133M = 1'b0;
        cmd_busy = 1'b0;
        repeat (10) begin
            @(negedge clk_133M);
            check("midrst_no_cmd", cmd_valid, 256'd0);
        end
        ddr_data_valid = 1'b1;
        tick();
        ddr_data_valid = 1'b0;
        @(negedge clk_133M);
        check("midrst_stale_ret_err", ret_err, 256'd1);
        check("midrst_stale_rd_valid", rd_valid, 256'd0);
        init_done = 1'b1;
        repeat (3) begin
            @(negedge clk_133M);
            check("midrst_flushed_no_cmd", cmd_valid, 256'd0);
        end
        tick();
        set_ch(3, 1'b1, 25'h0000710, {4{32'hFACE0001}});
        req[3] = 1'b1;
        @(negedge clk_133M);
        check("midrst_fresh_gnt", gnt, 256'd8);
        exp_cmd.push_back(mk_cmd(1'b1, 25'h0000710, {4{32'hFACE0001}}));
        tick();
        req = '0;
        drain_cmds("midrst_cmd_drain");

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
